regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-requester controller that shares one single-port 256×32 data register bank between the host bus and the SPI transfer engine. Accepts read/write commands from each requester over a req/gnt handshake, serializes them with round-robin arbitration, drives the bank's single write/read port, and returns read data with a valid pulse. Sits between the two requesters and the data register bank in the SPI subsystem.

## Interface
- ADDR_W, 8, register bank address width (256 entries)
- DATA_W, 32, data word width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  command request, requester 0 = host, 1 = SPI engine
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  command address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  keep ownership after this command (used only with REGFILE_ARB_LOCK_EN)
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted and issued to bank
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for that requester
- rdata0 / rdata1  out  DATA_W  read data, held until next rvalid for that requester
- mem_we  out  1  bank write enable
- mem_addr  out  ADDR_W  bank address
- mem_wdata  out  DATA_W  bank write data
- mem_rdata  in  DATA_W  bank read data, valid one cycle after address issued

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: if any req high, pick winner, register its we/addr/wdata into command register, go ISSUE; else stay.
- ISSUE: drive mem_addr/mem_wdata from command register; mem_we = cmd write; pulse gnt of winner. Write → IDLE. Read → RDWAIT.
- RDWAIT: capture mem_rdata into winner's rdata, pulse its rvalid, → IDLE.
- Arbitration: only one req high → that requester. Both high → requester not served last. last_winner resets to 1, so requester 0 wins first tie.
- Requester holds req/we/addr/wdata stable until its gnt; drops or changes them in the cycle after gnt. req still high after gnt = new command.
- Never more than one gnt or rvalid high per cycle; mem_we high only in ISSUE of a write.
- Reset: state IDLE, last_winner = 1, all gnt/rvalid/mem_we = 0, mem_addr/mem_wdata/rdata0/rdata1 = 0, lock-owner cleared. rst mid-transaction drops the command (no gnt/rvalid issued afterward); requester must re-request.

## Timing
- Request sampled in IDLE at cycle N → gnt and bank access in N+1.
- Write: bank written at edge ending N+1; back in IDLE at N+2. Throughput one write per 2 cycles.
- Read: mem_rdata sampled at end of N+2, rvalid/rdata visible N+3 (registered). Throughput one read per 3 cycles.
- Alternating both-requester load: strict alternation, no requester waits more than one other command.

## Configuration
- REGFILE_ARB_LOCK_EN defined: if winner's lock is high in its ISSUE cycle, it becomes lock-owner; in IDLE, owner's req is granted regardless of the other requester; ownership released when owner issues a command with lock low or owner's req is low in IDLE. last_winner still updated.
- Not defined: lock0/lock1 ignored, pure round-robin.

## Structure
- Package regfile_pkg: ADDR_W, DATA_W constants, state enum arb_state_t (IDLE, ISSUE, RDWAIT), struct regfile_cmd_t {we, addr, wdata}.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req vector and last_winner (plus lock-owner override under the macro).

## Test plan
- Reset then req0 write addr 0x10 data 0xDEADBEEF → gnt0 one cycle later with mem_we=1, mem_addr=0x10; later req0 read 0x10 → rvalid0 3 cycles after request, rdata0=0xDEADBEEF.
- req0 and req1 high same cycle, both reads → gnt0 first, then gnt1; continued both-high → strict alternation 0,1,0,1.
- req1 write 0x05=0x1 while req0 reads 0x05 concurrently → requester 0 wins tie, rdata0 = old value; next read returns 0x1.
- rst asserted in RDWAIT → no rvalid, all outputs 0 next cycle, FSM IDLE.
- With REGFILE_ARB_LOCK_EN, req1 three writes with lock1=1 while req0 high → three gnt1 back-to-back before gnt0; without macro → gnt alternates.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the data-register-bank arbiter.
// Optional feature macro: REGFILE_ARB_LOCK_EN (requester lock/ownership).
package regfile_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } regfile_cmd_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester handshakes and bank port of the register-bank arbiter.
// lock0/lock1 are only meaningful when REGFILE_ARB_LOCK_EN is defined.
interface regfile_arbiter_if;
  import regfile_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/regfile_arbiter_rr.sv
// Combinational two-way round-robin pick; with REGFILE_ARB_LOCK_EN a
// requesting lock owner overrides the round-robin choice.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_winner_i,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic       lock_valid_i,
  input  logic       lock_owner_i,
`endif
  output logic       any_o,
  output logic       winner_o
);

  logic rr_pick_s;

  // On a tie the requester not served last wins.
  always_comb begin
    if (req_i == 2'b11) begin
      rr_pick_s = ~last_winner_i;
    end else begin
      rr_pick_s = req_i[1];
    end
  end

  assign any_o = |req_i;

`ifdef REGFILE_ARB_LOCK_EN
  assign winner_o = (lock_valid_i && req_i[lock_owner_i]) ? lock_owner_i : rr_pick_s;
`else
  assign winner_o = rr_pick_s;
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Serializes host / SPI-engine commands onto one single-port register bank.
// Optional feature macro: REGFILE_ARB_LOCK_EN (lock-owner priority).
module regfile_arbiter
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  regfile_arbiter_if.slave   bus
);

  arb_state_t        state_q, state_d;
  regfile_cmd_t      cmd_q, cmd_d;
  logic              winner_q, winner_d;
  logic              last_winner_q, last_winner_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              mem_we_q, mem_we_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              lock_valid_q, lock_valid_d;
  logic              lock_owner_q, lock_owner_d;

  logic [1:0]        req_vec_s;
  logic              any_s, pick_s;
  regfile_cmd_t      cmd0_s, cmd1_s, sel_cmd_s;

  assign req_vec_s = {bus.req1, bus.req0};
  assign cmd0_s    = {bus.we0, bus.addr0, bus.wdata0};
  assign cmd1_s    = {bus.we1, bus.addr1, bus.wdata1};
  assign sel_cmd_s = pick_s ? cmd1_s : cmd0_s;

  rr_arbiter2 u_rr (
    .req_i         (req_vec_s),
    .last_winner_i (last_winner_q),
`ifdef REGFILE_ARB_LOCK_EN
    .lock_valid_i  (lock_valid_q),
    .lock_owner_i  (lock_owner_q),
`endif
    .any_o         (any_s),
    .winner_o      (pick_s)
  );

`ifdef REGFILE_ARB_LOCK_EN
  logic win_lock_s;
  assign win_lock_s = winner_q ? bus.lock1 : bus.lock0;
`else
  logic unused_lock_s;
  assign unused_lock_s = bus.lock0 ^ bus.lock1;
`endif

  // Next state; gnt/mem_we are registered so they appear in the ISSUE cycle.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    mem_we_d      = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    lock_valid_d  = lock_valid_q;
    lock_owner_d  = lock_owner_q;
    case (state_q)
      IDLE: begin
`ifdef REGFILE_ARB_LOCK_EN
        if (lock_valid_q && !req_vec_s[lock_owner_q]) begin
          lock_valid_d = 1'b0;
        end else begin
          lock_valid_d = lock_valid_q;
        end
`endif
        if (any_s) begin
          winner_d      = pick_s;
          last_winner_d = pick_s;
          cmd_d         = sel_cmd_s;
          gnt0_d        = ~pick_s;
          gnt1_d        = pick_s;
          mem_we_d      = sel_cmd_s.we;
          state_d       = ISSUE;
        end else begin
          state_d       = IDLE;
        end
      end
      ISSUE: begin
`ifdef REGFILE_ARB_LOCK_EN
        if (win_lock_s) begin
          lock_valid_d = 1'b1;
          lock_owner_d = winner_q;
        end else if (lock_valid_q && (lock_owner_q == winner_q)) begin
          lock_valid_d = 1'b0;
        end else begin
          lock_valid_d = lock_valid_q;
        end
`endif
        if (cmd_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (winner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = bus.mem_rdata;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      lock_valid_q  <= 1'b0;
      lock_owner_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      mem_we_q      <= mem_we_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      lock_valid_q  <= lock_valid_d;
      lock_owner_q  <= lock_owner_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: bank model, directed scenarios, then random
// traffic checked against a transaction-level reference model.
module tb_regfile_arbiter;

  logic clk;
  logic rst;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port bank with one-cycle registered read; cleared on reset.
  logic [31:0] bank [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank[i] <= 32'd0;
    end else if (bus.mem_we) begin
      bank[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= bank[bus.mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_rdata [2];
  int          m_last;
  int          m_owner;
  bit          p_valid [2];
  bit          p_we    [2];
  logic [7:0]  p_addr  [2];
  logic [31:0] p_wdata [2];
  bit          p_lock  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    bus.req0   = p_valid[0];
    bus.we0    = p_we[0];
    bus.addr0  = p_addr[0];
    bus.wdata0 = p_wdata[0];
    bus.lock0  = p_lock[0];
    bus.req1   = p_valid[1];
    bus.we1    = p_we[1];
    bus.addr1  = p_addr[1];
    bus.wdata1 = p_wdata[1];
    bus.lock1  = p_lock[1];
  endtask

  task automatic set_cmd(input int r, input bit we, input logic [7:0] addr,
                         input logic [31:0] wdata, input bit lock);
    p_valid[r] = 1'b1;
    p_we[r]    = we;
    p_addr[r]  = addr;
    p_wdata[r] = wdata;
    p_lock[r]  = lock;
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_owner = -1;
    m_rdata[0] = 32'd0;
    m_rdata[1] = 32'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    for (int r = 0; r < 2; r++) p_valid[r] = 1'b0;
  endtask

  function automatic int model_pick();
`ifdef REGFILE_ARB_LOCK_EN
    if (m_owner >= 0 && p_valid[m_owner]) return m_owner;
`endif
    if (p_valid[0] && p_valid[1]) return 1 - m_last;
    return p_valid[1] ? 1 : 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_we,
                              bus.mem_addr, bus.mem_wdata}), 64'd0);
    check({tag, "_rdata"}, {bus.rdata1, bus.rdata0}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  // Entered #1 after an edge with the arbiter idle; runs one full transaction.
  task automatic run_cycle();
    int w;
    logic [31:0] exp;
    apply_inputs();
`ifdef REGFILE_ARB_LOCK_EN
    if (m_owner >= 0 && !p_valid[m_owner]) m_owner = -1;
`endif
    @(posedge clk);
    #1;
    if (!p_valid[0] && !p_valid[1]) begin
      check("idle", 64'({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_we}), 64'd0);
      return;
    end
    w = model_pick();
    check("gnt", 64'({bus.gnt1, bus.gnt0}), (w == 1) ? 64'd2 : 64'd1);
    check("mem_we", 64'(bus.mem_we), 64'(p_we[w]));
    check("mem_addr", 64'(bus.mem_addr), 64'(p_addr[w]));
    if (p_we[w]) check("mem_wdata", 64'(bus.mem_wdata), 64'(p_wdata[w]));
    check("rvalid_in_issue", 64'({bus.rvalid1, bus.rvalid0}), 64'd0);
    m_last = w;
`ifdef REGFILE_ARB_LOCK_EN
    if (p_lock[w]) m_owner = w;
    else if (m_owner == w) m_owner = -1;
`endif
    p_valid[w] = 1'b0;
    if (p_we[w]) begin
      m_mem[p_addr[w]] = p_wdata[w];
      @(posedge clk);
      #1;
      check("after_write", 64'({bus.gnt1, bus.gnt0, bus.mem_we}), 64'd0);
    end else begin
      exp = m_mem[p_addr[w]];
      @(posedge clk);
      #1;
      apply_inputs();
      check("rdwait", 64'({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_we}), 64'd0);
      @(posedge clk);
      #1;
      m_rdata[w] = exp;
      check("rvalid", 64'({bus.rvalid1, bus.rvalid0}), (w == 1) ? 64'd2 : 64'd1);
      check("rdata_winner", 64'((w == 1) ? bus.rdata1 : bus.rdata0), 64'(exp));
      check("rdata_held", 64'((w == 1) ? bus.rdata0 : bus.rdata1), 64'(m_rdata[1 - w]));
    end
  endtask

  initial begin
    int nw;
    clk = 1'b0;
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      p_valid[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = 8'd0;
      p_wdata[r] = 32'd0; p_lock[r] = 1'b0;
    end
    do_reset();

    // Write then read back from requester 0
    set_cmd(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    run_cycle();
    set_cmd(0, 1'b0, 8'h10, 32'd0, 1'b0);
    run_cycle();
    check("readback", 64'(bus.rdata0), 64'h0000_0000_DEAD_BEEF);

    // Simultaneous reads: 0 first, then strict alternation
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 2; r++)
        if (!p_valid[r]) set_cmd(r, 1'b0, 8'(8'h20 + k + r), 32'd0, 1'b0);
      run_cycle();
    end

    // Concurrent write (1) and read (0) of the same address
    do_reset();
    set_cmd(1, 1'b1, 8'h05, 32'h1, 1'b0);
    set_cmd(0, 1'b0, 8'h05, 32'd0, 1'b0);
    run_cycle();
    check("old_value", 64'(bus.rdata0), 64'd0);
    run_cycle();
    set_cmd(0, 1'b0, 8'h05, 32'd0, 1'b0);
    run_cycle();
    check("new_value", 64'(bus.rdata0), 64'd1);

    // Reset while waiting for read data
    do_reset();
    set_cmd(0, 1'b1, 8'h33, 32'hCAFE_F00D, 1'b0);
    run_cycle();
    set_cmd(0, 1'b0, 8'h33, 32'd0, 1'b0);
    apply_inputs();
    @(posedge clk); #1;
    check("rd_gnt", 64'(bus.gnt0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    apply_inputs();
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("no_late_rvalid", 64'({bus.rvalid1, bus.rvalid0, bus.gnt1, bus.gnt0}), 64'd0);
    set_cmd(1, 1'b0, 8'h33, 32'd0, 1'b0);
    run_cycle();

    // Locked burst from requester 1 while requester 0 waits
    do_reset();
    set_cmd(0, 1'b1, 8'h40, 32'h4040, 1'b0);
    run_cycle();
    set_cmd(0, 1'b0, 8'h40, 32'd0, 1'b0);
    nw = 0;
    for (int k = 0; k < 6; k++) begin
      if (!p_valid[1] && nw < 3) begin
        set_cmd(1, 1'b1, 8'(8'h50 + nw), 32'(32'h100 + nw), 1'b1);
        nw++;
      end
      run_cycle();
    end
    p_lock[1] = 1'b0;

    // Random traffic over a small address window to force collisions
    do_reset();
    for (int k = 0; k < 200; k++) begin
      for (int r = 0; r < 2; r++)
        if (!p_valid[r] && ($urandom_range(0, 1) == 1))
          set_cmd(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 1'b0);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
